reg_window_ctrl: RTL and testbench
==================================

Name: reg_window_ctrl

Overview:
- Frame-pointer and window controller that drives the 128-entry windowed register file.
- Holds the current frame pointer (FP) and maps 3-bit window register indices to 7-bit absolute addresses.
- Sequences CALL/RTN window moves, including the FP_move strobe, offset and direction, and keeps a LIFO of frame offsets so each RTN restores the matching CALL.
- Sits between instruction decode and the register file.

Parameters:
- STACK_DEPTH, 16, number of nested CALL frames held in the offset LIFO.
- FP_MAX, 120, highest legal FP value, so the 8-register window never wraps past address 127.

Ports:
- Clock  in  1  system clock, rising edge
- nReset  in  1  asynchronous active-low reset
- Op_Valid  in  1  decode presents an operation
- Op_Ready  out  1  controller accepts the operation this cycle
- Op_Call  in  1  operation is CALL (qualified by Op_Valid)
- Op_Rtn  in  1  operation is RTN (qualified by Op_Valid)
- Call_Offset  in  3  CALL frame advance I; legal range 1..7
- Dec_Rd, Dec_Rs, Dec_Rm  in  3 each  window indices from decode
- Dec_Rd_Wen, Dec_Rs_Wen  in  1 each  decode write enables
- Rd_Addr, Rs_Addr, Rm_Addr  out  7 each  absolute register addresses
- Actual_Rd, Actual_Rs, Actual_Rm  out  3 each  window indices to the register file
- Rd_Wen, Rs_Wen  out  1 each  register-file write enables
- New_FP  out  7  frame pointer after the move
- FP_move  out  1  window move in progress this cycle
- FP_push_up  out  1  1 = RTN (FP decreasing), 0 = CALL (FP increasing)
- FP  out  7  current frame pointer
- Depth  out  5  LIFO occupancy, 0..STACK_DEPTH
- Fault  out  1  one-cycle pulse when an operation is rejected

Behaviour:
- Reset (asynchronous, nReset low):
  - State IDLE.
  - FP=0, Depth=0, LIFO contents don't-care.
  - Outputs: Op_Ready=1, FP_move=0, FP_push_up=0, Rd_Wen=0, Rs_Wen=0, Fault=0, New_FP=0.
  - Reset mid-move aborts the move with no partial FP update.
- States: IDLE, MOVE, SETTLE.
- IDLE:
  - Op_Ready=1.
  - Address mapping is combinational: X_Addr = FP + Dec_X, 7-bit sum.
  - Actual_X = Dec_X.
  - Wen outputs follow the decode enables. Zero latency for ordinary operations.
- Accept rules (in IDLE, when Op_Valid=1):
  - Op_Call and Op_Rtn both high: illegal. Fault pulses, no state change, and Rd_Wen/Rs_Wen are forced to 0 that cycle.
  - CALL is legal only if Call_Offset != 0, FP+Call_Offset <= FP_MAX, and Depth < STACK_DEPTH. Otherwise Fault pulses, the CALL is dropped, and Wens are forced to 0.
  - RTN is legal only if Depth > 0. Otherwise Fault pulses, the RTN is dropped, and Wens are forced to 0.
  - A legal CALL/RTN latches its Dec_Rd, Dec_Rd_Wen and offset, then goes to MOVE. A CALL pushes its offset; a RTN pops the top offset.
- MOVE (exactly one cycle):
  - Op_Ready=0, FP_move=1, Rs_Wen=0.
  - Actual_Rs = offset I, because the register file uses Actual_Rs as the move distance.
  - Actual_Rd = latched Dec_Rd, Rd_Wen = latched Dec_Rd_Wen, and Rd_Addr = old FP + latched Dec_Rd.
  - CALL: New_FP = FP+I, FP_push_up=0.
  - RTN: New_FP = FP−I, FP_push_up=1.
  - At the closing edge, FP <= New_FP and Depth updates by ±1. Then go to SETTLE.
- SETTLE (exactly one cycle):
  - Op_Ready=0, FP_move=0, all Wens 0.
  - Lets the register file's shadow window settle. Then return to IDLE.
- Throughput: CALL/RTN take 3 cycles from acceptance until the next operation is accepted. Op_Valid may stay high through MOVE/SETTLE; the held operation is accepted when Op_Ready returns.
- Arithmetic:
  - FP stays within 0..FP_MAX by construction.
  - RTN cannot underflow because offsets are popped in LIFO order, and FP returns exactly to its pre-CALL value.
- Fault is a registered one-cycle pulse and never coincides with FP_move=1.

Decomposition:
- Package reg_window_pkg holds:
  - the state enum (IDLE, MOVE, SETTLE);
  - constants REG_COUNT=128, WINDOW=8, FP_W=7, IDX_W=3.
- One sub-module, offset_lifo: STACK_DEPTH×3-bit stack with push, pop, top, count, full and empty.

Test Plan:
- Reset, then Dec_Rd=3 with Dec_Rd_Wen=1 → Rd_Addr=3, Rd_Wen=1, Op_Ready=1, FP=0.
- CALL with I=5, Dec_Rd=2, Dec_Rd_Wen=1 at FP=0 → next cycle FP_move=1, New_FP=5, FP_push_up=0, Actual_Rs=5, Rd_Addr=2. Then FP=5 and Depth=1; Op_Ready is 0 for 2 cycles, then 1.
- Nested CALLs I=3 then I=7 from FP=0, then two RTNs → FP goes 3, 10, 3, 0; the RTN moves show FP_push_up=1 with Actual_Rs=7 and then 3; Depth ends at 0.
- RTN at Depth=0, and CALL with I=0 → Fault pulses one cycle, FP unchanged, no FP_move, Wens 0.
- CALL with I=7 at FP=118 (118+7=125>120) → Fault pulses and FP stays 118. Separately, a 17th nested CALL with STACK_DEPTH=16 → Fault.
- nReset asserted during MOVE → immediate IDLE, FP=0, Depth=0, FP_move=0 without waiting for a clock edge.

Source files
------------

// File: rtl/reg_window_pkg.sv
// rtl/reg_window_pkg.sv - shared types and constants for the register window controller
package reg_window_pkg;

   localparam int REG_COUNT = 128;
   localparam int WINDOW    = 8;
   localparam int FP_W      = 7;
   localparam int IDX_W     = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVE   = 2'd1,
      SETTLE = 2'd2
   } win_state_e;

endpackage

// File: rtl/reg_window_ctrl_offset_lifo.sv
// rtl/reg_window_ctrl_offset_lifo.sv - LIFO of CALL frame offsets
module offset_lifo
   import reg_window_pkg::*;
#(
   parameter int STACK_DEPTH = 16,
   parameter int CNT_W       = 5
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic             push,
   input  logic             pop,
   input  logic [IDX_W-1:0] din,
   output logic [IDX_W-1:0] top,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [IDX_W-1:0] mem [STACK_DEPTH];

   assign full  = (count == CNT_W'(STACK_DEPTH));
   assign empty = (count == '0);
   assign top   = mem[0];

   // Occupancy counter; a push on full or a pop on empty is ignored.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         count <= '0;
      end else if (push && !full) begin
         count <= count + CNT_W'(1);
      end else if (pop && !empty) begin
         count <= count - CNT_W'(1);
      end
   end

   // Storage shifts so the newest offset always sits in entry 0, keeping top a plain wire.
   always_ff @(posedge Clock) begin
      if (push && !full) begin
         mem[0] <= din;
         for (int i = 1; i < STACK_DEPTH; i++) begin
            mem[i] <= mem[i-1];
         end
      end else if (pop && !empty) begin
         for (int i = 0; i < STACK_DEPTH - 1; i++) begin
            mem[i] <= mem[i+1];
         end
         mem[STACK_DEPTH-1] <= '0;
      end
   end

endmodule

// File: rtl/reg_window_ctrl.sv
// rtl/reg_window_ctrl.sv - frame pointer, window address mapping and CALL/RTN sequencing
module reg_window_ctrl
   import reg_window_pkg::*;
#(
   parameter int STACK_DEPTH = 16,
   parameter int FP_MAX      = REG_COUNT - WINDOW
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic             Op_Valid,
   output logic             Op_Ready,
   input  logic             Op_Call,
   input  logic             Op_Rtn,
   input  logic [IDX_W-1:0] Call_Offset,
   input  logic [IDX_W-1:0] Dec_Rd,
   input  logic [IDX_W-1:0] Dec_Rs,
   input  logic [IDX_W-1:0] Dec_Rm,
   input  logic             Dec_Rd_Wen,
   input  logic             Dec_Rs_Wen,
   output logic [FP_W-1:0]  Rd_Addr,
   output logic [FP_W-1:0]  Rs_Addr,
   output logic [FP_W-1:0]  Rm_Addr,
   output logic [IDX_W-1:0] Actual_Rd,
   output logic [IDX_W-1:0] Actual_Rs,
   output logic [IDX_W-1:0] Actual_Rm,
   output logic             Rd_Wen,
   output logic             Rs_Wen,
   output logic [FP_W-1:0]  New_FP,
   output logic             FP_move,
   output logic             FP_push_up,
   output logic [FP_W-1:0]  FP,
   output logic [4:0]       Depth,
   output logic             Fault
);

   localparam int DEPTH_W = 5;

   win_state_e       state, state_nxt;
   logic [FP_W-1:0]  fp_q;
   logic             fault_q;

   // Operation captured at acceptance and replayed during MOVE.
   logic             mv_rtn;
   logic [IDX_W-1:0] mv_off;
   logic [IDX_W-1:0] mv_rd;
   logic             mv_rd_wen;

   logic             lifo_push, lifo_pop, lifo_full, lifo_empty;
   logic [IDX_W-1:0] lifo_top;
   logic [DEPTH_W-1:0] lifo_count;

   logic             is_call, is_rtn, is_both;
   logic [FP_W:0]    call_sum;
   logic             call_ok, rtn_ok;
   logic             accept_call, accept_rtn, reject;

   assign is_both = Op_Valid & Op_Call & Op_Rtn;
   assign is_call = Op_Valid & Op_Call & ~Op_Rtn;
   assign is_rtn  = Op_Valid & Op_Rtn & ~Op_Call;

   // One extra bit so FP + offset cannot wrap before the FP_MAX compare.
   assign call_sum = {1'b0, fp_q} + (FP_W+1)'(Call_Offset);
   assign call_ok  = (Call_Offset != '0) && (call_sum <= (FP_W+1)'(FP_MAX)) && !lifo_full;
   assign rtn_ok   = !lifo_empty;

   assign accept_call = (state == IDLE) && is_call && call_ok;
   assign accept_rtn  = (state == IDLE) && is_rtn && rtn_ok;
   assign reject      = (state == IDLE) &&
                        (is_both || (is_call && !call_ok) || (is_rtn && !rtn_ok));

   assign Rs_Addr   = fp_q + FP_W'(Dec_Rs);
   assign Rm_Addr   = fp_q + FP_W'(Dec_Rm);
   assign Actual_Rm = Dec_Rm;
   assign FP        = fp_q;
   assign Depth     = lifo_count;
   assign Fault     = fault_q;

   // State register.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and outputs; Rd/Rs write enables are held off while in reset.
   always_comb begin
      state_nxt  = state;
      Op_Ready   = 1'b0;
      FP_move    = 1'b0;
      FP_push_up = 1'b0;
      Actual_Rd  = Dec_Rd;
      Actual_Rs  = Dec_Rs;
      Rd_Addr    = fp_q + FP_W'(Dec_Rd);
      Rd_Wen     = 1'b0;
      Rs_Wen     = 1'b0;
      New_FP     = fp_q;
      lifo_push  = 1'b0;
      lifo_pop   = 1'b0;
      case (state)
         IDLE: begin
            Op_Ready = 1'b1;
            Rd_Wen   = Dec_Rd_Wen & ~reject;
            Rs_Wen   = Dec_Rs_Wen & ~reject;
            if (accept_call || accept_rtn) begin
               state_nxt = MOVE;
            end
         end
         MOVE: begin
            FP_move    = 1'b1;
            FP_push_up = mv_rtn;
            Actual_Rs  = mv_off;
            Actual_Rd  = mv_rd;
            Rd_Addr    = fp_q + FP_W'(mv_rd);
            Rd_Wen     = mv_rd_wen;
            New_FP     = mv_rtn ? (fp_q - FP_W'(mv_off)) : (fp_q + FP_W'(mv_off));
            lifo_push  = ~mv_rtn;
            lifo_pop   = mv_rtn;
            state_nxt  = SETTLE;
         end
         SETTLE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (!nReset) begin
         Rd_Wen = 1'b0;
         Rs_Wen = 1'b0;
      end
   end

   // Frame pointer, fault pulse and the captured CALL/RTN operation.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         fp_q      <= '0;
         fault_q   <= 1'b0;
         mv_rtn    <= 1'b0;
         mv_off    <= '0;
         mv_rd     <= '0;
         mv_rd_wen <= 1'b0;
      end else begin
         fault_q <= reject;
         if (state == MOVE) begin
            fp_q <= New_FP;
         end
         if (accept_call || accept_rtn) begin
            mv_rtn    <= accept_rtn;
            mv_off    <= accept_rtn ? lifo_top : Call_Offset;
            mv_rd     <= Dec_Rd;
            mv_rd_wen <= Dec_Rd_Wen;
         end
      end
   end

   offset_lifo #(
      .STACK_DEPTH (STACK_DEPTH),
      .CNT_W       (DEPTH_W)
   ) u_offset_lifo (
      .Clock  (Clock),
      .nReset (nReset),
      .push   (lifo_push),
      .pop    (lifo_pop),
      .din    (mv_off),
      .top    (lifo_top),
      .count  (lifo_count),
      .full   (lifo_full),
      .empty  (lifo_empty)
   );

endmodule

// File: tb/tb_reg_window_ctrl.sv
// tb/tb_reg_window_ctrl.sv - self-checking bench for reg_window_ctrl
module tb_reg_window_ctrl;

   logic       Clock = 1'b0;
   logic       nReset = 1'b1;
   logic       Op_Valid = 1'b0, Op_Call = 1'b0, Op_Rtn = 1'b0;
   logic [2:0] Call_Offset = '0, Dec_Rd = '0, Dec_Rs = '0, Dec_Rm = '0;
   logic       Dec_Rd_Wen = 1'b0, Dec_Rs_Wen = 1'b0;

   logic       Op_Ready, Rd_Wen, Rs_Wen, FP_move, FP_push_up, Fault;
   logic [6:0] Rd_Addr, Rs_Addr, Rm_Addr, New_FP, FP;
   logic [2:0] Actual_Rd, Actual_Rs, Actual_Rm;
   logic [4:0] Depth;

   logic       d_Op_Ready, d_Rd_Wen, d_Rs_Wen, d_FP_move, d_FP_push_up, d_Fault;
   logic [6:0] d_Rd_Addr, d_Rs_Addr, d_Rm_Addr, d_New_FP, d_FP;
   logic [2:0] d_Actual_Rd, d_Actual_Rs, d_Actual_Rm;
   logic [4:0] d_Depth;

   int total = 0;
   int bad = 0;

   logic       obs_ready[4], obs_move[4], obs_fault[4], obs_pushup[4], obs_rdwen[4], obs_rswen[4], obs_fault2[4];
   logic [6:0] obs_fp[4], obs_newfp[4], obs_rdaddr[4], obs_rsaddr[4], obs_rmaddr[4], obs_fp2[4];
   logic [2:0] obs_ars[4], obs_ard[4];
   logic [4:0] obs_depth[4];
   logic [2:0] last_rm;

   always #5 Clock = ~Clock;

   reg_window_ctrl #(.STACK_DEPTH(16), .FP_MAX(120)) dut (
      .Clock(Clock), .nReset(nReset), .Op_Valid(Op_Valid), .Op_Ready(Op_Ready),
      .Op_Call(Op_Call), .Op_Rtn(Op_Rtn), .Call_Offset(Call_Offset),
      .Dec_Rd(Dec_Rd), .Dec_Rs(Dec_Rs), .Dec_Rm(Dec_Rm),
      .Dec_Rd_Wen(Dec_Rd_Wen), .Dec_Rs_Wen(Dec_Rs_Wen),
      .Rd_Addr(Rd_Addr), .Rs_Addr(Rs_Addr), .Rm_Addr(Rm_Addr),
      .Actual_Rd(Actual_Rd), .Actual_Rs(Actual_Rs), .Actual_Rm(Actual_Rm),
      .Rd_Wen(Rd_Wen), .Rs_Wen(Rs_Wen), .New_FP(New_FP), .FP_move(FP_move),
      .FP_push_up(FP_push_up), .FP(FP), .Depth(Depth), .Fault(Fault)
   );

   // Deeper stack so the FP_MAX boundary (118 + 7) is reachable.
   reg_window_ctrl #(.STACK_DEPTH(20), .FP_MAX(120)) dut_deep (
      .Clock(Clock), .nReset(nReset), .Op_Valid(Op_Valid), .Op_Ready(d_Op_Ready),
      .Op_Call(Op_Call), .Op_Rtn(Op_Rtn), .Call_Offset(Call_Offset),
      .Dec_Rd(Dec_Rd), .Dec_Rs(Dec_Rs), .Dec_Rm(Dec_Rm),
      .Dec_Rd_Wen(Dec_Rd_Wen), .Dec_Rs_Wen(Dec_Rs_Wen),
      .Rd_Addr(d_Rd_Addr), .Rs_Addr(d_Rs_Addr), .Rm_Addr(d_Rm_Addr),
      .Actual_Rd(d_Actual_Rd), .Actual_Rs(d_Actual_Rs), .Actual_Rm(d_Actual_Rm),
      .Rd_Wen(d_Rd_Wen), .Rs_Wen(d_Rs_Wen), .New_FP(d_New_FP), .FP_move(d_FP_move),
      .FP_push_up(d_FP_push_up), .FP(d_FP), .Depth(d_Depth), .Fault(d_Fault)
   );

   task automatic sample(input int k);
      obs_ready[k]  = Op_Ready;   obs_move[k]   = FP_move;   obs_fault[k] = Fault;
      obs_pushup[k] = FP_push_up; obs_rdwen[k]  = Rd_Wen;    obs_rswen[k] = Rs_Wen;
      obs_fp[k]     = FP;         obs_newfp[k]  = New_FP;    obs_rdaddr[k] = Rd_Addr;
      obs_rsaddr[k] = Rs_Addr;    obs_rmaddr[k] = Rm_Addr;   obs_ars[k]   = Actual_Rs;
      obs_ard[k]    = Actual_Rd;  obs_depth[k]  = Depth;     obs_fp2[k]   = d_FP;
      obs_fault2[k] = d_Fault;
   endtask

   // Present one operation for a single cycle, then record four cycles of outputs.
   task automatic run_op(input logic c, input logic r, input logic [2:0] off, input logic [2:0] rd,
                         input logic rdw, input logic [2:0] rs, input logic rsw);
      Op_Valid = 1'b1; Op_Call = c; Op_Rtn = r; Call_Offset = off;
      Dec_Rd = rd; Dec_Rd_Wen = rdw; Dec_Rs = rs; Dec_Rs_Wen = rsw;
      last_rm = 3'($urandom_range(7)); Dec_Rm = last_rm;
      @(negedge Clock); sample(0);
      @(posedge Clock); #1;
      Op_Valid = 1'b0; Op_Call = 1'b0; Op_Rtn = 1'b0; Call_Offset = 3'($urandom_range(7));
      Dec_Rd = rd ^ 3'b101; Dec_Rd_Wen = 1'b1; Dec_Rs_Wen = 1'b1;
      for (int k = 1; k < 4; k++) begin
         @(negedge Clock); sample(k);
         @(posedge Clock); #1;
      end
   endtask

   task automatic pulse_reset();
      Op_Valid = 1'b0; Op_Call = 1'b0; Op_Rtn = 1'b0;
      nReset = 1'b0; #2; nReset = 1'b1;
      @(posedge Clock); #1;
   endtask

   task automatic test_reset();
      Dec_Rd = 3'd3; Dec_Rd_Wen = 1'b1; Dec_Rs_Wen = 1'b1;
      #2 nReset = 1'b0;
      @(negedge Clock);
      total++; if (Op_Ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", Op_Ready); end
      total++; if (FP_move !== 1'b0 || FP_push_up !== 1'b0) begin bad++; $display("FAIL rst_move got=%0b%0b exp=00", FP_move, FP_push_up); end
      total++; if (Rd_Wen !== 1'b0 || Rs_Wen !== 1'b0) begin bad++; $display("FAIL rst_wen got=%0b%0b exp=00", Rd_Wen, Rs_Wen); end
      total++; if (Fault !== 1'b0 || New_FP !== 7'd0) begin bad++; $display("FAIL rst_fault_newfp got=%0b/%0d exp=0/0", Fault, New_FP); end
      total++; if (FP !== 7'd0 || Depth !== 5'd0) begin bad++; $display("FAIL rst_fp_depth got=%0d/%0d exp=0/0", FP, Depth); end
      @(posedge Clock); #1; nReset = 1'b1;
      @(negedge Clock);
      total++; if (Rd_Addr !== 7'd3 || Rd_Wen !== 1'b1) begin bad++; $display("FAIL map_rd3 got=%0d/%0b exp=3/1", Rd_Addr, Rd_Wen); end
      total++; if (Op_Ready !== 1'b1 || FP !== 7'd0) begin bad++; $display("FAIL idle_ready_fp got=%0b/%0d exp=1/0", Op_Ready, FP); end
      @(posedge Clock); #1;
   endtask

   task automatic test_call();
      run_op(1'b1, 1'b0, 3'd5, 3'd2, 1'b1, 3'd0, 1'b0);
      total++; if (obs_move[1] !== 1'b1 || obs_newfp[1] !== 7'd5) begin bad++; $display("FAIL call_move got=%0b/%0d exp=1/5", obs_move[1], obs_newfp[1]); end
      total++; if (obs_pushup[1] !== 1'b0 || obs_ars[1] !== 3'd5) begin bad++; $display("FAIL call_dir_ars got=%0b/%0d exp=0/5", obs_pushup[1], obs_ars[1]); end
      total++; if (obs_rdaddr[1] !== 7'd2 || obs_ard[1] !== 3'd2 || obs_rdwen[1] !== 1'b1) begin bad++; $display("FAIL call_rd got=%0d/%0d/%0b exp=2/2/1", obs_rdaddr[1], obs_ard[1], obs_rdwen[1]); end
      total++; if (obs_rswen[1] !== 1'b0 || obs_rdwen[2] !== 1'b0 || obs_rswen[2] !== 1'b0) begin bad++; $display("FAIL call_wen_gate got=%0b%0b%0b exp=000", obs_rswen[1], obs_rdwen[2], obs_rswen[2]); end
      total++; if ({obs_ready[0], obs_ready[1], obs_ready[2], obs_ready[3]} !== 4'b1001) begin bad++; $display("FAIL call_ready got=%b exp=1001", {obs_ready[0], obs_ready[1], obs_ready[2], obs_ready[3]}); end
      total++; if (obs_fp[3] !== 7'd5 || obs_depth[3] !== 5'd1) begin bad++; $display("FAIL call_fp_depth got=%0d/%0d exp=5/1", obs_fp[3], obs_depth[3]); end
      run_op(1'b0, 1'b1, 3'd0, 3'd1, 1'b0, 3'd0, 1'b0);
      total++; if (obs_pushup[1] !== 1'b1 || obs_ars[1] !== 3'd5 || obs_newfp[1] !== 7'd0) begin bad++; $display("FAIL call_rtn got=%0b/%0d/%0d exp=1/5/0", obs_pushup[1], obs_ars[1], obs_newfp[1]); end
      total++; if (obs_fp[3] !== 7'd0 || obs_depth[3] !== 5'd0) begin bad++; $display("FAIL call_rtn_fp got=%0d/%0d exp=0/0", obs_fp[3], obs_depth[3]); end
   endtask

   task automatic test_nested();
      logic [6:0] fps[4];
      logic [2:0] ars[2];
      logic       pu[2];
      run_op(1'b1, 1'b0, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0); fps[0] = obs_fp[3];
      run_op(1'b1, 1'b0, 3'd7, 3'd0, 1'b0, 3'd0, 1'b0); fps[1] = obs_fp[3];
      run_op(1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0); fps[2] = obs_fp[3]; ars[0] = obs_ars[1]; pu[0] = obs_pushup[1];
      run_op(1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0); fps[3] = obs_fp[3]; ars[1] = obs_ars[1]; pu[1] = obs_pushup[1];
      total++; if ({fps[0], fps[1], fps[2], fps[3]} !== {7'd3, 7'd10, 7'd3, 7'd0}) begin bad++; $display("FAIL nest_fp got=%0d,%0d,%0d,%0d exp=3,10,3,0", fps[0], fps[1], fps[2], fps[3]); end
      total++; if (ars[0] !== 3'd7 || ars[1] !== 3'd3) begin bad++; $display("FAIL nest_ars got=%0d,%0d exp=7,3", ars[0], ars[1]); end
      total++; if (pu[0] !== 1'b1 || pu[1] !== 1'b1) begin bad++; $display("FAIL nest_pushup got=%0b%0b exp=11", pu[0], pu[1]); end
      total++; if (obs_depth[3] !== 5'd0) begin bad++; $display("FAIL nest_depth got=%0d exp=0", obs_depth[3]); end
   endtask

   task automatic test_faults();
      logic [2:0] tc [3] = '{3'b010, 3'b100, 3'b110};
      for (int i = 0; i < 3; i++) begin
         logic [2:0] t;
         t = tc[i];
         run_op(t[2], t[1], (i == 2) ? 3'd3 : 3'd0, 3'd4, 1'b1, 3'd6, 1'b1);
         total++; if ({obs_fault[0], obs_fault[1], obs_fault[2]} !== 3'b010) begin bad++; $display("FAIL fault_pulse%0d got=%b exp=010", i, {obs_fault[0], obs_fault[1], obs_fault[2]}); end
         total++; if (obs_rdwen[0] !== 1'b0 || obs_rswen[0] !== 1'b0) begin bad++; $display("FAIL fault_wen%0d got=%0b%0b exp=00", i, obs_rdwen[0], obs_rswen[0]); end
         total++; if (obs_move[1] !== 1'b0 || obs_move[2] !== 1'b0) begin bad++; $display("FAIL fault_move%0d got=%0b%0b exp=00", i, obs_move[1], obs_move[2]); end
         total++; if (obs_fp[3] !== 7'd0 || obs_depth[3] !== 5'd0) begin bad++; $display("FAIL fault_fp%0d got=%0d/%0d exp=0/0", i, obs_fp[3], obs_depth[3]); end
      end
   endtask

   task automatic test_limits();
      pulse_reset();
      for (int i = 0; i < 16; i++) run_op(1'b1, 1'b0, 3'd7, 3'd0, 1'b0, 3'd0, 1'b0);
      total++; if (obs_fp[3] !== 7'd112 || obs_depth[3] !== 5'd16) begin bad++; $display("FAIL lim_fill got=%0d/%0d exp=112/16", obs_fp[3], obs_depth[3]); end
      run_op(1'b1, 1'b0, 3'd6, 3'd0, 1'b0, 3'd0, 1'b0);
      total++; if (obs_fault[1] !== 1'b1 || obs_fp[3] !== 7'd112 || obs_depth[3] !== 5'd16) begin bad++; $display("FAIL lim_full got=%0b/%0d/%0d exp=1/112/16", obs_fault[1], obs_fp[3], obs_depth[3]); end
      total++; if (obs_fault2[1] !== 1'b0 || obs_fp2[3] !== 7'd118) begin bad++; $display("FAIL lim_deep118 got=%0b/%0d exp=0/118", obs_fault2[1], obs_fp2[3]); end
      run_op(1'b1, 1'b0, 3'd7, 3'd0, 1'b0, 3'd0, 1'b0);
      total++; if (obs_fault2[1] !== 1'b1 || obs_fp2[3] !== 7'd118) begin bad++; $display("FAIL lim_fpmax got=%0b/%0d exp=1/118", obs_fault2[1], obs_fp2[3]); end
      run_op(1'b1, 1'b0, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0);
      total++; if (obs_fault2[1] !== 1'b0 || obs_fp2[3] !== 7'd120) begin bad++; $display("FAIL lim_fp120 got=%0b/%0d exp=0/120", obs_fault2[1], obs_fp2[3]); end
   endtask

   task automatic test_reset_mid_move();
      pulse_reset();
      run_op(1'b1, 1'b0, 3'd4, 3'd0, 1'b0, 3'd0, 1'b0);
      Op_Valid = 1'b1; Op_Call = 1'b1; Call_Offset = 3'd3; Dec_Rd = 3'd1;
      @(posedge Clock); #1;
      Op_Valid = 1'b0; Op_Call = 1'b0;
      total++; if (FP_move !== 1'b1 || FP !== 7'd4) begin bad++; $display("FAIL mid_pre got=%0b/%0d exp=1/4", FP_move, FP); end
      #1 nReset = 1'b0;
      #1;
      total++; if (FP_move !== 1'b0 || Op_Ready !== 1'b1) begin bad++; $display("FAIL mid_idle got=%0b/%0b exp=0/1", FP_move, Op_Ready); end
      total++; if (FP !== 7'd0 || Depth !== 5'd0 || New_FP !== 7'd0) begin bad++; $display("FAIL mid_clear got=%0d/%0d/%0d exp=0/0/0", FP, Depth, New_FP); end
      @(posedge Clock); #1;
      total++; if (FP !== 7'd0) begin bad++; $display("FAIL mid_hold got=%0d exp=0", FP); end
      nReset = 1'b1;
      @(posedge Clock); #1;
   endtask

   task automatic test_back_to_back();
      pulse_reset();
      for (int pass = 0; pass < 2; pass++) begin
         Op_Valid = 1'b1; Op_Call = (pass == 0); Op_Rtn = (pass == 1); Call_Offset = 3'd1;
         for (int c = 0; c < 9; c++) begin
            @(negedge Clock);
            total++; if (Op_Ready !== (c % 3 == 0) || FP_move !== (c % 3 == 1)) begin bad++; $display("FAIL b2b%0d_c%0d got=%0b/%0b exp=%0b/%0b", pass, c, Op_Ready, FP_move, c % 3 == 0, c % 3 == 1); end
            @(posedge Clock); #1;
         end
         Op_Valid = 1'b0; Op_Call = 1'b0; Op_Rtn = 1'b0;
         @(negedge Clock);
         total++; if (FP !== ((pass == 0) ? 7'd3 : 7'd0) || Depth !== ((pass == 0) ? 5'd3 : 5'd0)) begin bad++; $display("FAIL b2b%0d_end got=%0d/%0d exp=%0d/%0d", pass, FP, Depth, (pass == 0) ? 3 : 0, (pass == 0) ? 3 : 0); end
         @(posedge Clock); #1;
      end
   endtask

   // Random operations against a plain-arithmetic model: FP as an int, offsets in a queue.
   task automatic test_random();
      int fp_m;
      int stk[$];
      pulse_reset();
      fp_m = 0;
      for (int n = 0; n < 60; n++) begin
         int sel, exp_fp, used;
         logic c, r, rdw, rsw, legal, plain, mv;
         logic [2:0] off, rd, rs;
         sel = $urandom_range(99);
         c = (sel < 45) || (sel >= 85 && sel < 93);
         r = (sel >= 45 && sel < 93);
         plain = (sel >= 93);
         off = 3'($urandom_range(7)); rd = 3'($urandom_range(7)); rs = 3'($urandom_range(7));
         rdw = 1'($urandom_range(1)); rsw = 1'($urandom_range(1));
         if (c && r) legal = 1'b0;
         else if (c) legal = (off != 0) && (fp_m + off <= 120) && (stk.size() < 16);
         else if (r) legal = (stk.size() > 0);
         else legal = 1'b1;
         mv = legal && !plain;
         exp_fp = fp_m; used = off;
         run_op(c, r, off, rd, rdw, rs, rsw);
         total++; if (obs_ready[0] !== 1'b1 || obs_rdaddr[0] !== 7'(fp_m + rd) || obs_rsaddr[0] !== 7'(fp_m + rs) || obs_rmaddr[0] !== 7'(fp_m + last_rm)) begin bad++; $display("FAIL rnd%0d_map got=%0b/%0d/%0d/%0d fp=%0d", n, obs_ready[0], obs_rdaddr[0], obs_rsaddr[0], obs_rmaddr[0], fp_m); end
         total++; if (obs_rdwen[0] !== (legal & rdw) || obs_rswen[0] !== (legal & rsw)) begin bad++; $display("FAIL rnd%0d_wen got=%0b%0b exp=%0b%0b", n, obs_rdwen[0], obs_rswen[0], legal & rdw, legal & rsw); end
         total++; if (obs_fault[1] !== !legal || obs_move[1] !== mv) begin bad++; $display("FAIL rnd%0d_fault_move got=%0b/%0b exp=%0b/%0b", n, obs_fault[1], obs_move[1], !legal, mv); end
         if (mv) begin
            if (c) begin exp_fp = fp_m + off; stk.push_back(int'(off)); end
            else begin used = stk.pop_back(); exp_fp = fp_m - used; end
            total++; if (obs_newfp[1] !== 7'(exp_fp) || obs_pushup[1] !== r || obs_ars[1] !== 3'(used)) begin bad++; $display("FAIL rnd%0d_move got=%0d/%0b/%0d exp=%0d/%0b/%0d", n, obs_newfp[1], obs_pushup[1], obs_ars[1], exp_fp, r, used); end
            total++; if (obs_rdaddr[1] !== 7'(fp_m + rd) || obs_rdwen[1] !== rdw || obs_rswen[1] !== 1'b0) begin bad++; $display("FAIL rnd%0d_mvrd got=%0d/%0b/%0b exp=%0d/%0b/0", n, obs_rdaddr[1], obs_rdwen[1], obs_rswen[1], 7'(fp_m + rd), rdw); end
         end
         total++; if (obs_ready[2] !== !mv || obs_rdwen[2] !== !mv || obs_fault[2] !== 1'b0) begin bad++; $display("FAIL rnd%0d_settle got=%0b/%0b/%0b exp=%0b/%0b/0", n, obs_ready[2], obs_rdwen[2], obs_fault[2], !mv, !mv); end
         total++; if (obs_fp[3] !== 7'(exp_fp) || obs_depth[3] !== 5'(stk.size()) || obs_ready[3] !== 1'b1) begin bad++; $display("FAIL rnd%0d_end got=%0d/%0d/%0b exp=%0d/%0d/1", n, obs_fp[3], obs_depth[3], obs_ready[3], exp_fp, stk.size()); end
         fp_m = exp_fp;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_call();
      test_nested();
      test_faults();
      test_limits();
      test_reset_mid_move();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
